// File: rtl/spi_command_master.sv
// SPI mode-0 command master: sends one byte MSB first on MOSI and captures the reply byte from MISO.
// The sequence per frame is select setup, 8 SCLK periods, select hold, then an inter-frame gap.
module spi_command_master #(
  parameter int CLK_DIV   = 25,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic       busy,
  output logic       SCLK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);

  // One phase counter covers SETUP, HOLD and GAP, so it is sized for the longest of the three.
  localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((HOLD_CYC  > GAP_CYC) ? HOLD_CYC  : GAP_CYC);
  localparam int PW = (PH_MAX  > 1) ? $clog2(PH_MAX)  : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [2:0]      bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic            sclk_q, sclk_d;
  logic            ss_q, ss_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic [7:0]      resp_data_q, resp_data_d;
  logic            resp_valid_q, resp_valid_d;

  assign cmd_ready  = (state_q == S_IDLE);
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign SCLK       = sclk_q;
  assign SS         = ss_q;
  assign MOSI       = mosi_q;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_d        = bit_q;
    div_d        = div_q;
    ph_d         = ph_q;
    sclk_d       = sclk_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          tx_d    = cmd_data;
          mosi_d  = cmd_data[7];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = 3'd7;
          ph_d    = '0;
        end
      end
      S_SETUP: begin
        if (ph_q == PW'(SETUP_CYC - 1)) begin
          state_d = S_SHIFT;
          ph_d    = '0;
          div_d   = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture the line the slave has held stable all low phase.
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], MISO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = S_HOLD;
              ph_d    = '0;
            end else begin
              bit_d  = bit_q - 3'd1;
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HOLD: begin
        if (ph_q == PW'(HOLD_CYC - 1)) begin
          state_d      = S_GAP;
          ph_d         = '0;
          ss_d         = 1'b1;
          mosi_d       = 1'b0;
          resp_data_d  = rx_q;
          resp_valid_d = 1'b1;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_GAP: begin
        if (ph_q == PW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          ph_d    = '0;
          busy_d  = 1'b0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; a low rst_n discards any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      ph_q         <= '0;
      sclk_q       <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      ph_q         <= ph_d;
      sclk_q       <= sclk_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_command_master.sv
// Bench for spi_command_master: small-parameter DUT with a mode-0 slave model, plus a default-parameter DUT in loopback.
module tb_spi_command_master;

  localparam int P_DIV   = 2;
  localparam int P_SETUP = 1;
  localparam int P_HOLD  = 1;
  localparam int P_GAP   = 2;
  localparam int EXP_RV  = P_SETUP + 16*P_DIV + P_HOLD + 1;
  localparam int EXP_SSL = P_SETUP + 16*P_DIV + P_HOLD;
  localparam int FR_LEN  = P_SETUP + 16*P_DIV + P_HOLD + P_GAP + 1;

  logic       clk = 0, rst_n = 0;
  logic [7:0] cmd_data = 0;
  logic       cmd_valid = 0;
  logic       cmd_ready, resp_valid, busy, sclk, ss, mosi, miso;
  logic [7:0] resp_data;

  logic [7:0] c2_data = 0;
  logic       c2_valid = 0;
  logic       c2_ready, c2_rv, c2_busy, c2_sclk, c2_ss, c2_mosi;
  logic [7:0] c2_rd;

  int n_chk = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_command_master #(.CLK_DIV(P_DIV), .SETUP_CYC(P_SETUP), .HOLD_CYC(P_HOLD), .GAP_CYC(P_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .busy(busy),
    .SCLK(sclk), .SS(ss), .MOSI(mosi), .MISO(miso));

  spi_command_master #(.CLK_DIV(25), .SETUP_CYC(4), .HOLD_CYC(4), .GAP_CYC(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_data(c2_data), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .resp_data(c2_rd), .resp_valid(c2_rv), .busy(c2_busy),
    .SCLK(c2_sclk), .SS(c2_ss), .MOSI(c2_mosi), .MISO(c2_mosi));

  // Mode-0 slave: first reply bit presented on select, next bit after each SCLK fall.
  logic [7:0] slave_reply = 0, slave_sr = 0;
  bit         loopback = 0;
  always @(negedge ss) slave_sr = slave_reply;
  always @(negedge sclk) if (!ss) slave_sr = {slave_sr[6:0], 1'b0};
  assign miso = loopback ? mosi : slave_sr[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: the reply is the 8 line values seen at the 8 sample points, first one landing in the MSB.
  function automatic logic [7:0] model_resp(input logic [7:0] tx, input logic [7:0] reply, input bit lb);
    logic [7:0] line, r;
    line = lb ? tx : reply;
    r = 0;
    for (int i = 7; i >= 0; i--) r = r * 2 + {7'd0, line[i]};
    return r;
  endfunction

  // Results of the last do_frame call, offsets counted in cycles after the accept edge.
  int         fr_rises, fr_rv_off, fr_rv_cnt, fr_ss_low, fr_ss_first, fr_ss_last;
  logic [7:0] fr_mosi, fr_rx;

  task automatic do_frame(input logic [7:0] tx, input logic [7:0] reply, input bit lb, input bit poke);
    int n;
    logic prev;
    slave_reply = reply;
    loopback = lb;
    @(negedge clk);
    cmd_data = tx;
    cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_wait", (n < 200), 1);
    @(posedge clk);
    fr_rises = 0; fr_rv_off = 0; fr_rv_cnt = 0; fr_ss_low = 0; fr_ss_first = 0; fr_ss_last = 0;
    fr_mosi = 0; fr_rx = 0; prev = 0;
    for (int k = 1; k <= FR_LEN; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      if (poke) begin
        if (k == 10) begin cmd_valid = 1; cmd_data = 8'hFF; end
        if (k == 12) cmd_valid = 0;
        if (k == 10 || k == 11) chk("ready_low_busy", cmd_ready, 0);
      end
      if (sclk && !prev) begin fr_rises++; fr_mosi = {fr_mosi[6:0], mosi}; end
      prev = sclk;
      if (!ss) begin
        fr_ss_low++;
        if (fr_ss_first == 0) fr_ss_first = k;
        fr_ss_last = k;
      end
      if (resp_valid) begin fr_rv_cnt++; fr_rv_off = k; fr_rx = resp_data; end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] reply;
    bit         lb;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, r, rv, lows, acc, nrv, hi_run, r1, r2;
    int acc_t[2];
    int rises_f[2];
    logic [7:0] mosi_f[2];
    logic [7:0] rx_f[2];
    logic prev, pending;
    logic [7:0] t, rp;
    bit lb;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'h3C};
    vecs[1] = '{8'h00, 8'h77, 1'b1, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'hFF};
    vecs[3] = '{8'h80, 8'h11, 1'b1, 8'h80};
    vecs[4] = '{8'h01, 8'hEE, 1'b1, 8'h01};
    vecs[5] = '{8'h5A, 8'hC3, 1'b0, 8'hC3};

    // Reset, with cmd_valid asserted to show it is ignored.
    cmd_valid = 1; cmd_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_ss", ss, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ss2", c2_ss, 1);
    cmd_valid = 0;
    rst_n = 1;
    @(negedge clk);

    // Single frame with exact timing.
    do_frame(8'hA5, 8'h3C, 0, 0);
    chk("t1_mosi", fr_mosi, 8'hA5);
    chk("t1_rx", fr_rx, 8'h3C);
    chk("t1_rises", fr_rises, 8);
    chk("t1_rv_off", fr_rv_off, EXP_RV);
    chk("t1_rv_cnt", fr_rv_cnt, 1);
    chk("t1_ss_first", fr_ss_first, 1);
    chk("t1_ss_last", fr_ss_last, EXP_SSL);
    chk("t1_ss_low", fr_ss_low, EXP_SSL);
    chk("t1_idle_ready", cmd_ready, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_resp_held", resp_data, 8'h3C);

    // Reset mid-frame after the third SCLK rise.
    slave_reply = 8'h5A; loopback = 0;
    @(negedge clk);
    cmd_data = 8'hC3; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("t4_accept_wait", (n < 200), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    prev = sclk; r = 0; n = 0;
    while (r < 3 && n < 60) begin
      @(negedge clk);
      if (sclk && !prev) r++;
      prev = sclk;
      n++;
    end
    chk("t4_rise3", r, 3);
    rst_n = 0;
    @(negedge clk);
    chk("t4_ss", ss, 1);
    chk("t4_sclk", sclk, 0);
    chk("t4_resp_data", resp_data, 0);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    rv = 0; lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (resp_valid) rv++;
      if (!ss) lows++;
    end
    chk("t4_no_rv", rv, 0);
    chk("t4_no_ss", lows, 0);

    // Table vectors.
    foreach (vecs[i]) begin
      do_frame(vecs[i].tx, vecs[i].reply, vecs[i].lb, 0);
      chk($sformatf("vec%0d_mosi", i), fr_mosi, vecs[i].tx);
      chk($sformatf("vec%0d_rx", i), fr_rx, vecs[i].exp_rx);
      chk($sformatf("vec%0d_rises", i), fr_rises, 8);
      chk($sformatf("vec%0d_rvcnt", i), fr_rv_cnt, 1);
    end

    // Busy hold-off: a 0xFF pulse mid-frame must not be taken.
    do_frame(8'h10, 8'h00, 1, 1);
    chk("t3_mosi", fr_mosi, 8'h10);
    chk("t3_rx", fr_rx, 8'h10);
    chk("t3_rises", fr_rises, 8);
    repeat (3) @(negedge clk);
    chk("t3_no_accept", busy, 0);
    chk("t3_ss_idle", ss, 1);

    // Random frames against the model.
    for (int i = 0; i < 10; i++) begin
      t  = 8'($urandom);
      rp = 8'($urandom);
      lb = 1'($urandom_range(0, 1));
      do_frame(t, rp, lb, 0);
      chk($sformatf("rnd%0d_mosi", i), fr_mosi, t);
      chk($sformatf("rnd%0d_rx", i), fr_rx, model_resp(t, rp, lb));
      chk($sformatf("rnd%0d_rv_off", i), fr_rv_off, EXP_RV);
    end

    // Back-to-back with cmd_valid held.
    slave_reply = 8'h99; loopback = 0;
    @(negedge clk);
    cmd_data = 8'h01; cmd_valid = 1;
    acc = 0; nrv = 0; hi_run = 0; prev = 0; pending = 0;
    rises_f = '{0, 0}; mosi_f = '{0, 0}; rx_f = '{0, 0}; acc_t = '{0, 0};
    for (int k = 0; k < 120; k++) begin
      if (k > 0) @(negedge clk);
      if (sclk && !prev && acc > 0) begin
        rises_f[acc-1]++;
        mosi_f[acc-1] = {mosi_f[acc-1][6:0], mosi};
      end
      prev = sclk;
      if (acc == 1 && ss) hi_run++;
      if (resp_valid && nrv < 2) begin rx_f[nrv] = resp_data; nrv++; end
      if (pending) begin cmd_data = 8'h02; pending = 0; end
      if (acc == 2 && cmd_valid) cmd_valid = 0;
      if (cmd_ready && cmd_valid && acc < 2) begin acc_t[acc] = cyc; acc++; pending = (acc == 1); end
    end
    cmd_valid = 0;
    chk("t2_accepts", acc, 2);
    chk("t2_period", acc_t[1] - acc_t[0], 1 + P_SETUP + 16*P_DIV + P_HOLD + P_GAP);
    chk("t2_gap_ok", (hi_run >= P_GAP), 1);
    chk("t2_rises0", rises_f[0], 8);
    chk("t2_rises1", rises_f[1], 8);
    chk("t2_mosi0", mosi_f[0], 8'h01);
    chk("t2_mosi1", mosi_f[1], 8'h02);
    chk("t2_nrv", nrv, 2);
    chk("t2_rx0", rx_f[0], 8'h99);
    chk("t2_rx1", rx_f[1], 8'h99);

    // Default parameters, loopback.
    @(negedge clk);
    c2_data = 8'h55; c2_valid = 1;
    n = 0;
    while (!c2_ready && n < 200) begin @(negedge clk); n++; end
    chk("t6_accept_wait", (n < 200), 1);
    @(posedge clk);
    r = 0; r1 = 0; r2 = 0; lows = 0; rv = 0; prev = 0; t = 0; rp = 0; nrv = 0;
    for (int k = 1; k <= 830; k++) begin
      @(negedge clk);
      if (k == 1) c2_valid = 0;
      if (c2_sclk && !prev) begin
        r++;
        t = {t[6:0], c2_mosi};
        if (r == 1) r1 = k;
        if (r == 2) r2 = k;
      end
      prev = c2_sclk;
      if (!c2_ss) lows++;
      if (c2_rv) begin rv = k; rp = c2_rd; nrv++; end
    end
    chk("t6_rises", r, 8);
    chk("t6_period", r2 - r1, 50);
    chk("t6_ss_low", lows, 4 + 400 + 4);
    chk("t6_rv_off", rv, 4 + 400 + 4 + 1);
    chk("t6_rv_cnt", nrv, 1);
    chk("t6_rx", rp, 8'h55);
    chk("t6_mosi", t, 8'h55);
    chk("t6_idle", c2_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
